// File: rtl/computer_system_pio_in_if.sv
// ---------------------------------------------------------------------------
// computer_system_pio_in_if
// Avalon-MM slave bus for the PIO input block.
//   address    [1:0]  word address
//   chipselect        slave select
//   write_n           active-low write strobe, qualified by chipselect
//   writedata  [31:0] write data
//   readdata   [31:0] registered read data (slave -> master)
// ---------------------------------------------------------------------------
interface computer_system_pio_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );
endinterface

// File: rtl/computer_system_pio_in.sv
// ---------------------------------------------------------------------------
// computer_system_pio_in
// Parallel input port with a two-flop synchroniser, edge capture and a
// maskable level interrupt, exposed as an Avalon-MM slave.
//
// Ports
//   clk      single clock, rising edge
//   reset    synchronous, active-high
//   avs      Avalon-MM slave bus (computer_system_pio_in_if.slave)
//   in_port  [WIDTH-1:0] asynchronous external inputs
//   irq      active-high level interrupt = |(edge_capture & irq_mask)
//
// Register map (word address)
//   0  data          RO   synchronised input, zero-extended
//   1  reserved      reads 0, writes ignored
//   2  irq_mask      RW   WIDTH bits
//   3  edge_capture  R/W1C
//
// Build option
//   PIO_IN_ANY_EDGE_EN  defined: capture rising and falling edges
//                       undefined (default): capture rising edges only
// ---------------------------------------------------------------------------
module computer_system_pio_in #(
  parameter int               WIDTH      = 10,
  parameter logic [WIDTH-1:0] RESET_MASK = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  computer_system_pio_in_if.slave       avs,
  input  logic [WIDTH-1:0]              in_port,
  output logic                          irq
);

  logic [WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [1:0]       prime_cnt_q, prime_cnt_d;

  logic             primed;
  logic             wr_en;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_bits;

  // Upper writedata bits have no destination when WIDTH < 32.
  logic unused_writedata;
  assign unused_writedata = ^avs.writedata;

  // The synchroniser needs three cycles after reset before s2/s3 hold real
  // history; edges seen before that are just the pipeline filling.
  assign primed = (prime_cnt_q == 2'd3);

`ifdef PIO_IN_ANY_EDGE_EN
  assign edge_det = s2_q ^ s3_q;
`else
  assign edge_det = s2_q & ~s3_q;
`endif

  // NOTE: every signal assigned in this block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_en       = avs.chipselect & ~avs.write_n;
    mask_d      = mask_q;
    clr_bits    = '0;
    readdata_d  = '0;
    prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + 2'd1;

    if (wr_en && avs.address == 2'd2) mask_d   = avs.writedata[WIDTH-1:0];
    if (wr_en && avs.address == 2'd3) clr_bits = avs.writedata[WIDTH-1:0];

    // Clear first, then set, so a same-cycle set wins.
    capture_d = (capture_q & ~clr_bits) | (primed ? edge_det : '0);

    // Read data is decoded every cycle, regardless of chipselect.
    unique case (avs.address)
      2'd0:    readdata_d = 32'(s2_q);
      2'd2:    readdata_d = 32'(mask_q);
      2'd3:    readdata_d = 32'(capture_q);
      default: readdata_d = '0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values; s1->s2->s3 stays a true shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      capture_q   <= '0;
      readdata_q  <= '0;
      prime_cnt_q <= '0;
      mask_q      <= RESET_MASK;
    end else begin
      s1_q        <= in_port;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      capture_q   <= capture_d;
      readdata_q  <= readdata_d;
      prime_cnt_q <= prime_cnt_d;
      mask_q      <= mask_d;
    end
  end

  assign avs.readdata = readdata_q;
  assign irq          = |(capture_q & mask_q);

endmodule

// File: tb/tb_computer_system_pio_in.sv
module tb_computer_system_pio_in;

  localparam int WIDTH = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  computer_system_pio_in_if bus ();

  computer_system_pio_in #(
    .WIDTH      (WIDTH),
    .RESET_MASK (10'h001)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .avs     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

`ifdef PIO_IN_ANY_EDGE_EN
  localparam logic [31:0] FALL_EXP   = 32'h001;
  localparam logic [31:0] BIT2_EXP   = 32'h005;
`else
  localparam logic [31:0] FALL_EXP   = 32'h000;
  localparam logic [31:0] BIT2_EXP   = 32'h004;
`endif

  typedef struct {
    logic [WIDTH-1:0] in_val;
    logic [1:0]       addr;
    logic [31:0]      exp;
    string            name;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    cycle(1);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    cycle(1);
    d = bus.readdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;

    vecs[0] = '{10'h2A5, 2'd0, 32'h0000_02A5, "data_2a5"};
    vecs[1] = '{10'h15A, 2'd0, 32'h0000_015A, "data_15a"};
    vecs[2] = '{10'h000, 2'd1, 32'h0000_0000, "rsvd_lo"};
    vecs[3] = '{10'h3FF, 2'd1, 32'h0000_0000, "rsvd_hi"};
    vecs[4] = '{10'h3FF, 2'd2, 32'h0000_0001, "mask_reset"};
    vecs[5] = '{10'h001, 2'd0, 32'h0000_0001, "data_001"};
    vecs[6] = '{10'h001, 2'd3, 32'h0000_03FF, "capture_acc"};

    // Reset with all inputs high: priming must hide the pipeline-fill edge.
    reset          = 1'b1;
    in_port        = 10'h3FF;
    bus.address    = 2'd3;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    cycle(2);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_readdata", bus.readdata, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(1);
      check($sformatf("prime_irq_%0d", i), 32'(irq), 32'h0);
      check($sformatf("prime_cap_%0d", i), bus.readdata, 32'h0);
    end
    do_read(2'd2, rd); check("mask_after_reset", rd, 32'h001);

    // Table-driven reads.
    for (int i = 0; i < 7; i++) begin
      in_port = vecs[i].in_val;
      cycle(3);
      bus.address = vecs[i].addr;
      cycle(1);
      check(vecs[i].name, bus.readdata, vecs[i].exp);
    end
    check("irq_bit0_masked_in", 32'(irq), 32'h1);

    // Reserved address ignores writes.
    do_write(2'd1, 32'hFFFF_FFFF);
    do_read(2'd1, rd); check("rsvd_after_write", rd, 32'h0);
    do_read(2'd2, rd); check("mask_untouched", rd, 32'h001);
    do_read(2'd3, rd); check("cap_untouched", rd, 32'h3FF);

    // Clear everything, mask everything off.
    do_write(2'd3, 32'h3FF);
    do_read(2'd3, rd); check("clear_all", rd, 32'h0);
    check("irq_after_clear", 32'(irq), 32'h0);
    do_write(2'd2, 32'h0);
    do_read(2'd2, rd); check("mask_zero", rd, 32'h0);

    // Rising edge on bit 3 with exact latency.
    bus.address = 2'd3;
    in_port     = 10'h009;
    cycle(3);
    check("latency_early", bus.readdata, 32'h0);
    cycle(1);
    check("latency_k3", bus.readdata, 32'h008);
    check("irq_masked", 32'(irq), 32'h0);
    do_write(2'd2, 32'h008);
    check("irq_unmask", 32'(irq), 32'h1);

    // Clear colliding with a new bit 3 edge: set wins.
    in_port = 10'h001;
    cycle(4);
    in_port = 10'h009;
    cycle(2);
    do_write(2'd3, 32'h008);
    do_read(2'd3, rd); check("collision_set_wins", rd, 32'h008);
    check("collision_irq", 32'(irq), 32'h1);

    // Plain clear; a held level does not re-set the bit.
    do_write(2'd3, 32'h008);
    do_read(2'd3, rd); check("plain_clear", rd, 32'h0);
    check("plain_clear_irq", 32'(irq), 32'h0);
    cycle(3);
    do_read(2'd3, rd); check("level_no_reset", rd, 32'h0);

    // A fresh rising edge after the clear captures again.
    in_port = 10'h001;
    cycle(4);
    do_write(2'd3, 32'h008);
    in_port = 10'h009;
    cycle(4);
    do_read(2'd3, rd); check("recapture", rd, 32'h008);
    check("recapture_irq", 32'(irq), 32'h1);

    // Falling edge on bit 0.
    do_write(2'd3, 32'h3FF);
    do_read(2'd3, rd); check("pre_fall_clear", rd, 32'h0);
    in_port = 10'h008;
    cycle(4);
    do_read(2'd3, rd); check("falling_edge", rd, FALL_EXP);
    check("falling_irq", 32'(irq), 32'h0);

    // Mid-test reset with a capture pending and a write in the reset cycle.
    in_port = 10'h00C;
    cycle(4);
    do_read(2'd3, rd); check("pending_before_reset", rd, BIT2_EXP);
    reset          = 1'b1;
    bus.address    = 2'd2;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = 32'h3FF;
    cycle(1);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    check("midreset_irq", 32'(irq), 32'h0);
    check("midreset_readdata", bus.readdata, 32'h0);
    cycle(1);
    reset = 1'b0;
    cycle(5);
    do_read(2'd2, rd); check("midreset_mask", rd, 32'h001);
    do_read(2'd3, rd); check("midreset_cap", rd, 32'h0);
    check("midreset_irq_after", 32'(irq), 32'h0);

    // Real edge after priming, unmasked by RESET_MASK.
    in_port = 10'h00D;
    cycle(4);
    check("post_prime_irq", 32'(irq), 32'h1);
    do_read(2'd3, rd); check("post_prime_cap", rd, 32'h001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
